qam16_mapper: RTL and testbench

Streaming 16-QAM mapper between the byte source and the IFFT framing stage of the 32-subcarrier OFDM transmitter. It accepts 8-bit bytes over a valid/ready handshake, splits each byte into two 4-bit nibbles, and Gray-maps each nibble to one signed I/Q constellation point. Points are emitted as 64-bit words at up to one per cycle. A last flag marks every 32nd point, so each OFDM symbol's subcarrier block is delimited for the IFFT.

---
 rtl/qam16_pkg.sv | 31 +++
 rtl/qam16_lut.sv | 24 ++
 rtl/qam16_mapper.sv | 93 +++++++++
 tb/tb_qam16_mapper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// Shared 16-QAM definitions: Gray level codes, default subcarrier count and the
// {Q,I} word packing expected by the IFFT framing stage.
package qam16_pkg;

    localparam int N_SC_DEF   = 32;
    localparam int COMP_W_DEF = 32;
    localparam int AMP_DEF    = 8192;

    // Q occupies the upper half of the output word, I the lower half.
    localparam int Q_HALF = 1;
    localparam int I_HALF = 0;

    typedef enum logic [1:0] {
        G_M3 = 2'b00,
        G_M1 = 2'b01,
        G_P1 = 2'b11,
        G_P3 = 2'b10
    } gray_e;

    function automatic int gray_level(input logic [1:0] g);
        int lvl;
        case (gray_e'(g))
            G_M3:    lvl = -3;
            G_M1:    lvl = -1;
            G_P1:    lvl = 1;
            default: lvl = 3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/qam16_lut.sv
// Combinational nibble -> {Q,I} constellation point; I from bits [1:0], Q from [3:2].
module qam16_lut
    import qam16_pkg::*;
#(
    parameter int COMP_W = COMP_W_DEF,
    parameter int AMP    = AMP_DEF
) (
    input  logic [3:0]          nib_i,
    output logic [2*COMP_W-1:0] qi_o
);

    logic signed [COMP_W-1:0] i_s;
    logic signed [COMP_W-1:0] q_s;

    always_comb begin
        // signed int product, sign-extended (or truncated) to the component width
        i_s = COMP_W'(gray_level(nib_i[1:0]) * AMP);
        q_s = COMP_W'(gray_level(nib_i[3:2]) * AMP);
        qi_o = '0;
        qi_o[Q_HALF*COMP_W +: COMP_W] = q_s;
        qi_o[I_HALF*COMP_W +: COMP_W] = i_s;
    end

endmodule

// File: rtl/qam16_mapper.sv
// Streaming 16-QAM mapper: bytes in, two Gray-mapped points out (low nibble first),
// with m_last on every N_SC-th point to frame OFDM symbols.
module qam16_mapper
    import qam16_pkg::*;
#(
    parameter int COMP_W = COMP_W_DEF,
    parameter int AMP    = AMP_DEF,
    parameter int N_SC   = N_SC_DEF
) (
    input  logic                aclk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*COMP_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last
);

    localparam int              SC_W   = $clog2(N_SC);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(N_SC - 1);

    logic [7:0]          buf_q, buf_d;
    logic [1:0]          nib_cnt_q, nib_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic [2*COMP_W-1:0] m_data_q, m_data_d;
    logic                m_last_q, m_last_d;
    logic [SC_W-1:0]     sc_cnt_q, sc_cnt_d;

    logic                out_free, accept, load, hs;
    logic [3:0]          nib_sel;
    logic [2*COMP_W-1:0] point;
    logic [SC_W-1:0]     sc_next, load_idx;

    assign out_free = !m_valid_q || m_ready;
    assign in_ready = (nib_cnt_q == 2'd0) || ((nib_cnt_q == 2'd1) && out_free);
    assign accept   = in_valid && in_ready;
    assign load     = out_free && (nib_cnt_q != 2'd0);
    assign hs       = m_valid_q && m_ready;
    assign nib_sel  = (nib_cnt_q == 2'd2) ? buf_q[3:0] : buf_q[7:4];
    assign sc_next  = (sc_cnt_q == SC_MAX) ? '0 : sc_cnt_q + 1'b1;
    // A point loaded while the current one leaves takes the following index.
    assign load_idx = hs ? sc_next : sc_cnt_q;

    qam16_lut #(.COMP_W(COMP_W), .AMP(AMP)) u_lut (
        .nib_i (nib_sel),
        .qi_o  (point)
    );

    always_comb begin
        buf_d     = buf_q;
        nib_cnt_d = nib_cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        sc_cnt_d  = hs ? sc_next : sc_cnt_q;

        if (load) begin
            nib_cnt_d = nib_cnt_q - 2'd1;
            m_data_d  = point;
            m_last_d  = (load_idx == SC_MAX);
        end
        if (out_free) m_valid_d = load;
        if (accept) begin
            buf_d     = in_data;
            nib_cnt_d = 2'd2;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            buf_q     <= '0;
            nib_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            sc_cnt_q  <= '0;
        end else begin
            buf_q     <= buf_d;
            nib_cnt_q <= nib_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            sc_cnt_q  <= sc_cnt_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_qam16_mapper.sv
// Scoreboard bench for qam16_mapper: accepted bytes push expected points, a
// negedge monitor pops and compares every output handshake.
module tb_qam16_mapper;

    localparam logic [31:0] L_M3 = 32'hFFFF_A000;
    localparam logic [31:0] L_M1 = 32'hFFFF_E000;
    localparam logic [31:0] L_P1 = 32'h0000_2000;
    localparam logic [31:0] L_P3 = 32'h0000_6000;

    logic        aclk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    int n_cmp = 0;
    int n_err = 0;
    int pt_cnt = 0;
    int acc_cnt = 0;

    logic [63:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;

    qam16_mapper dut (
        .aclk     (aclk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] lvl(input logic [1:0] g);
        case (g)
            2'b00:   return L_M3;
            2'b01:   return L_M1;
            2'b11:   return L_P1;
            default: return L_P3;
        endcase
    endfunction

    function automatic logic [63:0] pt(input logic [3:0] n);
        return {lvl(n[3:2]), lvl(n[1:0])};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (reset) begin
            exp_q.delete();
            pt_cnt = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {63'd0, m_valid}, 64'd1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", {63'd0, m_last}, {63'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_point", m_data, 64'hx);
                end else begin
                    chk("point_data", m_data, exp_q.pop_front());
                    chk("point_last", {63'd0, m_last}, {63'd0, (pt_cnt % 32) == 31});
                end
                pt_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(pt(in_data[3:0]));
                exp_q.push_back(pt(in_data[7:4]));
                acc_cnt++;
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic do_reset();
        @(posedge aclk); #1;
        reset = 1'b1; in_valid = 1'b0; m_ready = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge aclk);
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        in_valid = 1'b1;
        in_data  = b;
        r = 1'b0;
        for (int t = 0; t < 50 && !r; t++) begin
            @(negedge aclk);
            r = in_ready;
            @(posedge aclk); #1;
        end
        if (!r) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        in_valid = 1'b0;
        m_ready  = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 200) begin
            @(posedge aclk); #1;
            t++;
        end
        if (t >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int a0, t;
        reset = 1'b1; in_valid = 1'b0; m_ready = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge aclk);
        #1 reset = 1'b0;
        @(negedge aclk);
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_data", m_data, 64'd0);
        chk("rst_last", {63'd0, m_last}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge aclk); #1;

        // constant 0xAA at full rate: 32 bytes, m_last on points 32 and 64
        in_valid = 1'b1; in_data = 8'hAA; m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge aclk);
            chk("in_ready_toggle", {63'd0, in_ready}, {63'd0, (i % 2) == 0});
            @(posedge aclk); #1;
        end
        drain();
        chk("aa_points", 64'(pt_cnt), 64'd64);

        // directed bytes
        do_reset();
        m_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'hFF);
        send_byte(8'h1E);
        drain();

        // stall right after the first point is presented
        do_reset();
        a0 = acc_cnt;
        in_valid = 1'b1; in_data = 8'h1E; m_ready = 1'b0;
        t = 0;
        while (!m_valid && t < 20) begin
            @(posedge aclk); #1;
            t++;
        end
        chk("stall_first_valid", {63'd0, m_valid}, 64'd1);
        in_data = 8'h99;
        repeat (10) @(posedge aclk);
        #1;
        chk("stall_accepts", 64'(acc_cnt - a0), 64'd1);
        in_valid = 1'b0; m_ready = 1'b1;
        @(negedge aclk);
        chk("release_pt0", {63'd0, m_valid}, 64'd1);
        @(negedge aclk);
        chk("release_pt1", {63'd0, m_valid}, 64'd1);
        @(negedge aclk);
        chk("release_idle", {63'd0, m_valid}, 64'd0);
        drain();

        // random handshakes on both sides
        for (int i = 0; i < 300; i++) begin
            m_ready  = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(posedge aclk); #1;
        end
        drain();

        // reset mid-byte after 20 points, high nibble pending
        do_reset();
        in_valid = 1'b1; in_data = 8'h3C; m_ready = 1'b1;
        t = 0;
        while (pt_cnt < 20 && t < 100) begin
            @(posedge aclk); #1;
            t++;
        end
        in_valid = 1'b0; m_ready = 1'b0;
        chk("pre_reset_valid", {63'd0, m_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, m_valid}, 64'd0);
        chk("async_rst_data", m_data, 64'd0);
        chk("async_rst_last", {63'd0, m_last}, 64'd0);
        repeat (2) @(posedge aclk);
        #1 reset = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));
        drain();
        chk("post_reset_points", 64'(pt_cnt), 64'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
